// File: rtl/cpu_io_pkg.sv
// Shared types and default constants for the CPU I/O blocks.
package cpu_io_pkg;

    typedef enum logic {STABLE, SETTLE} debounce_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/io_synchroniser.sv
// Multi-flop synchroniser for asynchronous inputs; all stages reset to 0.
module io_synchroniser #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clock,
    input  logic             i_n_reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [STAGES-1:0][WIDTH-1:0] r_stages;

    // Shift the asynchronous word through the flop chain.
    always_ff @(posedge i_clock or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[STAGES-1];

endmodule

// File: rtl/switch_input_port.sv
// Synchronised, debounced switch input port for the CPU input bus.
// Optional feature macro: SWITCH_OVERRUN_EN (sticky overrun detection;
// when undefined the overrun output is tied to 0).
module switch_input_port #(
    parameter int unsigned WORD_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = cpu_io_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = cpu_io_pkg::DEFAULT_SYNC_STAGES
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [WORD_W-1:0] raw_switches,
    input  logic              rd,
    output logic [WORD_W-1:0] switches,
    output logic              data_ready,
    output logic              overrun
);

    import cpu_io_pkg::*;

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WORD_W-1:0] w_sync;

    debounce_state_t   r_state,     w_state_next;
    logic [WORD_W-1:0] r_candidate, w_candidate_next;
    logic [WORD_W-1:0] r_stable,    w_stable_next;
    logic [CNT_W-1:0]  r_count,     w_count_next;
    logic              r_data_ready, w_data_ready_next;
    logic              w_commit;

    io_synchroniser #(
        .WIDTH  (WORD_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clock   (clock),
        .i_n_reset (n_reset),
        .i_async   (raw_switches),
        .o_sync    (w_sync)
    );

    // Debounce FSM: track a candidate word until it has held for DEBOUNCE_CYCLES.
    always_comb begin
        w_state_next     = r_state;
        w_candidate_next = r_candidate;
        w_stable_next    = r_stable;
        w_count_next     = r_count;
        w_commit         = 1'b0;
        case (r_state)
            STABLE: begin
                if (w_sync != r_stable) begin
                    w_candidate_next = w_sync;
                    w_count_next     = '0;
                    w_state_next     = SETTLE;
                end
            end
            SETTLE: begin
                if (w_sync != r_candidate) begin
                    // Bounce: restart the settle window on the new value.
                    w_candidate_next = w_sync;
                    w_count_next     = '0;
                end else if (r_count == CNT_LAST) begin
                    w_state_next = STABLE;
                    // A glitch that returned to the old word commits nothing.
                    if (r_candidate != r_stable) begin
                        w_stable_next = r_candidate;
                        w_commit      = 1'b1;
                    end
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            default: w_state_next = STABLE;
        endcase
    end

    // data_ready: a commit wins over a read landing in the same cycle.
    always_comb begin
        w_data_ready_next = r_data_ready;
        if (rd && r_data_ready) begin
            w_data_ready_next = 1'b0;
        end
        if (w_commit) begin
            w_data_ready_next = 1'b1;
        end
    end

    // Debounce state and handshake flag registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= STABLE;
            r_candidate  <= '0;
            r_stable     <= '0;
            r_count      <= '0;
            r_data_ready <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_candidate  <= w_candidate_next;
            r_stable     <= w_stable_next;
            r_count      <= w_count_next;
            r_data_ready <= w_data_ready_next;
        end
    end

    assign switches   = r_stable;
    assign data_ready = r_data_ready;

`ifdef SWITCH_OVERRUN_EN
    logic r_overrun, w_overrun_next;

    // Overrun: set when an unread word is overwritten; a read clears it, even
    // when a new commit lands on the same edge, since the old word was consumed.
    always_comb begin
        w_overrun_next = r_overrun;
        if (rd && r_data_ready) begin
            w_overrun_next = 1'b0;
        end
        if (w_commit && r_data_ready && !rd) begin
            w_overrun_next = 1'b1;
        end
    end

    // Sticky overrun register.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_overrun_next;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_port.sv
// Directed self-checking bench for switch_input_port (default parameters).
module tb_switch_input_port;

    logic       clock;
    logic       n_reset;
    logic [7:0] raw_switches;
    logic       rd;
    logic [7:0] switches;
    logic       data_ready;
    logic       overrun;

    int checks;
    int errors;

`ifdef SWITCH_OVERRUN_EN
    localparam logic OV_EXP = 1'b1;
`else
    localparam logic OV_EXP = 1'b0;
`endif

    switch_input_port dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .raw_switches (raw_switches),
        .rd           (rd),
        .switches     (switches),
        .data_ready   (data_ready),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Advance n rising edges; land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        n_reset      = 1'b0;
        raw_switches = 8'd3;
        rd           = 1'b0;
        step(3);
        checks++;
        if (switches !== 8'd0) begin
            errors++; $display("FAIL reset_sw: got %0d expected 0", switches);
        end
        checks++;
        if (data_ready !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got dr=%b ov=%b expected 0 0", data_ready, overrun);
        end
        n_reset = 1'b1;
        step(6);
        checks++;
        if (data_ready !== 1'b0 || switches !== 8'd0) begin
            errors++; $display("FAIL reset_early: got dr=%b sw=%0d expected 0 0", data_ready, switches);
        end
        step(1);
        checks++;
        if (switches !== 8'd3 || data_ready !== 1'b1) begin
            errors++; $display("FAIL reset_commit: got sw=%0d dr=%b expected 3 1", switches, data_ready);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL reset_commit_ov: got %b expected 0", overrun);
        end
    endtask

    task automatic test_read();
        pulse_rd();
        checks++;
        if (data_ready !== 1'b0 || switches !== 8'd3) begin
            errors++; $display("FAIL read_clear: got dr=%b sw=%0d expected 0 3", data_ready, switches);
        end
        raw_switches = 8'd5;
        step(6);
        checks++;
        if (switches !== 8'd3 || data_ready !== 1'b0) begin
            errors++; $display("FAIL read_early: got sw=%0d dr=%b expected 3 0", switches, data_ready);
        end
        step(1);
        checks++;
        if (switches !== 8'd5 || data_ready !== 1'b1) begin
            errors++; $display("FAIL read_commit: got sw=%0d dr=%b expected 5 1", switches, data_ready);
        end
        pulse_rd();
        checks++;
        if (data_ready !== 1'b0 || switches !== 8'd5) begin
            errors++; $display("FAIL read_ack: got dr=%b sw=%0d expected 0 5", data_ready, switches);
        end
        // Read while nothing is pending must be ignored.
        pulse_rd();
        step(1);
        checks++;
        if (data_ready !== 1'b0 || switches !== 8'd5 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: got dr=%b sw=%0d ov=%b expected 0 5 0",
                     data_ready, switches, overrun);
        end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        raw_switches = 8'd2;
        step(2);
        if (data_ready !== 1'b0 || switches !== 8'd5) bad++;
        raw_switches = 8'd5;
        step(2);
        if (data_ready !== 1'b0 || switches !== 8'd5) bad++;
        raw_switches = 8'd2;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (data_ready !== 1'b0 || switches !== 8'd5) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bounce_hold: got %0d early commits expected 0", bad);
        end
        step(1);
        checks++;
        if (switches !== 8'd2 || data_ready !== 1'b1) begin
            errors++; $display("FAIL bounce_commit: got sw=%0d dr=%b expected 2 1", switches, data_ready);
        end
        pulse_rd();
        checks++;
        if (data_ready !== 1'b0) begin
            errors++; $display("FAIL bounce_ack: got dr=%b expected 0", data_ready);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        raw_switches = 8'd32;
        step(2);
        raw_switches = 8'd2;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (switches !== 8'd2 || data_ready !== 1'b0 || overrun !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL glitch: got %0d bad cycles expected 0 (sw=%0d dr=%b)",
                               bad, switches, data_ready);
        end
    endtask

    task automatic test_overrun();
        raw_switches = 8'd7;
        step(7);
        checks++;
        if (switches !== 8'd7 || data_ready !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: got sw=%0d dr=%b ov=%b expected 7 1 0",
                     switches, data_ready, overrun);
        end
        raw_switches = 8'd9;
        step(7);
        checks++;
        if (switches !== 8'd9 || data_ready !== 1'b1) begin
            errors++; $display("FAIL overrun_second: got sw=%0d dr=%b expected 9 1", switches, data_ready);
        end
        checks++;
        if (overrun !== OV_EXP) begin
            errors++; $display("FAIL overrun_flag: got %b expected %b", overrun, OV_EXP);
        end
        pulse_rd();
        checks++;
        if (data_ready !== 1'b0 || overrun !== 1'b0 || switches !== 8'd9) begin
            errors++;
            $display("FAIL overrun_ack: got dr=%b ov=%b sw=%0d expected 0 0 9",
                     data_ready, overrun, switches);
        end
    endtask

    task automatic test_commit_rd();
        raw_switches = 8'd4;
        step(7);
        raw_switches = 8'd6;
        step(7);
        checks++;
        if (switches !== 8'd6 || data_ready !== 1'b1 || overrun !== OV_EXP) begin
            errors++;
            $display("FAIL coincide_setup: got sw=%0d dr=%b ov=%b expected 6 1 %b",
                     switches, data_ready, overrun, OV_EXP);
        end
        raw_switches = 8'd10;
        step(6);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        checks++;
        if (switches !== 8'd10 || data_ready !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL coincide: got sw=%0d dr=%b ov=%b expected 10 1 0",
                     switches, data_ready, overrun);
        end
        pulse_rd();
        checks++;
        if (data_ready !== 1'b0) begin
            errors++; $display("FAIL coincide_ack: got dr=%b expected 0", data_ready);
        end
    endtask

    task automatic test_reset_mid_settle();
        raw_switches = 8'd12;
        step(4);
        n_reset = 1'b0;
        #1;
        checks++;
        if (switches !== 8'd0 || data_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: got sw=%0d dr=%b expected 0 0", switches, data_ready);
        end
        step(2);
        n_reset = 1'b1;
        step(6);
        checks++;
        if (switches !== 8'd0 || data_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_early: got sw=%0d dr=%b expected 0 0", switches, data_ready);
        end
        step(1);
        checks++;
        if (switches !== 8'd12 || data_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_commit: got sw=%0d dr=%b expected 12 1", switches, data_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read();
        test_bounce();
        test_glitch();
        test_overrun();
        test_commit_rd();
        test_reset_mid_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_input_port.md
# switch_input_port

Synchronised, debounced input port that presents the board slide switches to the CPU's input bus. It implements the writer side of the CPU's switch-read path: it captures a new settled switch word, raises `data_ready`, and holds the word until the CPU acknowledges it with a read strobe. It sits between the top-level pins and `cpu2`'s `switches` input.

## Interface
- `WORD_W`, 8, width of the switch word
- `DEBOUNCE_CYCLES`, 4, number of consecutive cycles a synchronised value must stay unchanged before it is accepted; legal range is 2 or more
- `SYNC_STAGES`, 2, depth of the input synchroniser; legal range is 2 or more
- `clock`  in  1  system clock, rising edge
- `n_reset`  in  1  asynchronous, active-low reset
- `raw_switches`  in  WORD_W  asynchronous switch pins
- `rd`  in  1  CPU read strobe; a one-cycle pulse acknowledges the current word
- `switches`  out  WORD_W  last accepted (debounced) word, held between commits
- `data_ready`  out  1  a new word has been committed and not yet read
- `overrun`  out  1  sticky flag: a commit occurred while `data_ready` was already 1

## Operation
- Reset (asynchronous, `n_reset`=0):
  - synchroniser flops, `candidate`, `stable`/`switches` and `count` clear to 0
  - `data_ready` and `overrun` clear to 0
  - the FSM goes to STABLE
- Synchroniser: `raw_switches` passes through `SYNC_STAGES` flops; all later logic sees only the output `sync`.
- FSM states: STABLE, SETTLE.
  - STABLE, `sync` != `stable`: `candidate` <= `sync`, `count` <= 0, go to SETTLE.
  - STABLE, `sync` == `stable`: stay in STABLE.
  - SETTLE, `sync` != `candidate`: `candidate` <= `sync`, `count` <= 0, stay in SETTLE (bounce restarts the count).
  - SETTLE, `count` == `DEBOUNCE_CYCLES`-1: go to STABLE. If `candidate` != `stable`, commit: `stable` <= `candidate`.
  - SETTLE, any other case: `count` increments.
- Glitch return: if the switches bounce back to the old value, `candidate` == `stable` at the end of SETTLE. No commit occurs and there are no flag changes.
- Commit: sets `data_ready` to 1. If `data_ready` was already 1 and no `rd` occurs in that cycle, it also sets `overrun` (subject to Configuration).
- `rd` while `data_ready`=1: clears `data_ready` and `overrun` at the next edge.
- `rd` while `data_ready`=0: ignored.
- Commit and `rd` in the same cycle: the commit wins. `data_ready` stays 1, `switches` takes the new word, and `overrun` is cleared, because the read consumed the previous word.
- `count` width is `$clog2(DEBOUNCE_CYCLES)`. It never wraps, because it is reset or left at `DEBOUNCE_CYCLES`-1.

## Timing
- Latency: a change on `raw_switches` that is stable from just before edge 1 appears on `switches` and `data_ready` after edge `SYNC_STAGES`+1+`DEBOUNCE_CYCLES`. With the defaults, that is edge 7.
- Bounce rejection: a pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles never commits.
- `switches`, `data_ready` and `overrun` are registered. There is no combinational path from any input to any output.
- `rd` is sampled at the rising edge; its effect is visible in the following cycle.
- Reset mid-SETTLE: the pending candidate is discarded. After release the port re-acquires the current pins with full latency and commits if they are nonzero.

## Configuration
- `SWITCH_OVERRUN_EN` defined: the overrun detection logic is compiled in and behaves as described above.
- `SWITCH_OVERRUN_EN` undefined: the logic is omitted and `overrun` is tied to 0. The port list is unchanged, so instantiations do not differ between builds.

## Structure
- Shared package `cpu_io_pkg`:
  - `typedef enum logic {STABLE, SETTLE} debounce_state_t`
  - default constants for `DEBOUNCE_CYCLES` and `SYNC_STAGES`
- Sub-module `io_synchroniser`, parameterised by width and stage count, reset asynchronously to 0. It is reused for any future asynchronous input.

## Test plan
All times assume the 20 ns clock used by the CPU bench.
- Reset release with `raw_switches`=3: `switches`=0 and `data_ready`=0 during reset. `switches`=3 and `data_ready`=1 after edge 7.
- Change to 5, then pulse `rd` for one cycle: `switches`=5 and `data_ready`=1 after 7 edges. `data_ready`=0 one cycle after `rd`, and `switches` stays 5.
- Bounce `raw_switches` 5→2→5→2 with 2-cycle dwell, then hold at 2: no commit during the bounce. `switches`=2 exactly 7 edges after the final transition.
- Glitch 2→32 for 2 cycles, then back to 2: `switches` stays 2 and `data_ready` does not change.
- Two commits (values 7, then 9) with no `rd`: `switches`=9 and `data_ready`=1. `overrun`=1 with `SWITCH_OVERRUN_EN` defined, 0 without it. `rd` then clears both flags.
- Commit coincident with `rd` (a new word landing on the edge where `rd`=1): `data_ready` stays 1, `switches` takes the new word, `overrun`=0.
